// File: rtl/adder_pkg.sv
// Shared adder definitions: operand width, sum width (operand sum plus carry-out)
// and the sum type used by the adder and its capture FIFO.
package adder_pkg;

    localparam int unsigned OPND_W = 64;
    localparam int unsigned SUM_W  = OPND_W + 1;

    typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/sum_capture_fifo.sv
// First-word-fall-through FIFO capturing adder results, with a saturating
// count of accepted sums whose carry-out bit is set.
module sum_capture_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SUM_W  = adder_pkg::SUM_W,
    parameter int unsigned CCNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [SUM_W-1:0]          in_sum,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [SUM_W-1:0]          out_sum,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CCNT_W-1:0]         carry_cnt,
    input  logic                      clr_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [SUM_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flags derive only from the registered level, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (level != LW'(DEPTH));
        out_valid = (level != '0);
        out_sum   = mem[rd_ptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Storage is not reset; contents behind an empty FIFO are never presented as valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            carry_cnt <= '0;
        end else if (push && in_sum[SUM_W-1] && (carry_cnt != '1)) begin
            carry_cnt <= carry_cnt + CCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Scoreboard bench for sum_capture_fifo: a queue-based reference model predicts
// contents, occupancy and carry count; a negedge monitor compares the DUT against it.
module tb_sum_capture_fifo;

    localparam int DEPTH = 4;
    localparam int CMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [64:0] in_sum = '0;
    logic        in_ready;
    logic        out_valid;
    logic [64:0] out_sum;
    logic        out_ready = 1'b0;
    logic [2:0]  level;
    logic [15:0] carry_cnt;
    logic        clr_cnt = 1'b0;

    sum_capture_fifo #(.DEPTH(4), .SUM_W(65), .CCNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .level     (level),
        .carry_cnt (carry_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    logic [64:0] exp_q[$];
    int cur_level = 0;
    int cur_carry = 0;
    int nxt_level = 0;
    int nxt_carry = 0;
    bit armed = 1'b0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: status against the model every cycle, head data against the scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            chk("level", 65'(level), 65'(cur_level));
            chk("in_ready", 65'(in_ready), 65'(cur_level != DEPTH));
            chk("out_valid", 65'(out_valid), 65'(cur_level != 0));
            chk("carry_cnt", 65'(carry_cnt), 65'(cur_carry));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL head at %0t: got %h expected no entry", $time, out_sum);
                end else begin
                    chk("head", out_sum, exp_q[0]);
                end
            end
            if (out_valid === 1'b1 && out_ready && rst_n && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    // One clock cycle of stimulus; the model predicts the state after the edge.
    task automatic step(input logic v, input logic [64:0] s, input logic ordy,
                        input logic clr, input logic rn);
        bit push;
        bit pop;
        in_valid  = v;
        in_sum    = s;
        out_ready = ordy;
        clr_cnt   = clr;
        rst_n     = rn;
        push = rn && v && (cur_level != DEPTH);
        pop  = rn && ordy && (cur_level != 0);
        if (push) exp_q.push_back(s);
        if (!rn) begin
            nxt_level = 0;
            nxt_carry = 0;
        end else begin
            nxt_level = cur_level + int'(push) - int'(pop);
            if (clr) nxt_carry = 0;
            else if (push && s[64] && cur_carry < CMAX) nxt_carry = cur_carry + 1;
            else nxt_carry = cur_carry;
        end
        @(posedge clk);
        #1;
        if (!rn) exp_q.delete();
        cur_level = nxt_level;
        cur_carry = nxt_carry;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, ordy, 1'b0, 1'b1);
    endtask

    function automatic logic [64:0] rnd_sum();
        return {1'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    localparam logic [64:0] CARRY = 65'h1_0000_0000_0000_0000;

    initial begin
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        armed = 1'b1;
        idle(1'b1);

        // Single push into empty FIFO, held, then drained
        step(1'b1, 65'd3, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill to full, extra push ignored, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 65'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 65'd99, 1'b0, 1'b0, 1'b1);
        step(1'b1, 65'd77, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Carry counting and clear priority
        for (int i = 0; i < 3; i++) step(1'b1, CARRY, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b1, CARRY | 65'd5, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Streaming push/pop across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 65'(i), 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-operation discards contents; no push/pop on the reset cycle
        for (int i = 0; i < 3; i++) step(1'b1, CARRY | 65'(i + 40), 1'b0, 1'b0, 1'b1);
        step(1'b1, 65'd55, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Randomized traffic including occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_sum(), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 199) != 0));
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Saturation of the carry counter
        for (int i = 0; i < CMAX; i++) step(1'b1, CARRY | 65'(i), 1'b1, 1'b0, 1'b1);
        step(1'b1, CARRY | 65'd7, 1'b1, 1'b0, 1'b1);
        step(1'b1, CARRY | 65'd8, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sum_capture_fifo.md
SUM_CAPTURE_FIFO -- requirements
Module: sum_capture_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter SUM_W, default 65, sum width: 64-bit operand sum plus carry-out.
REQ-003 Parameter CCNT_W, default 16, carry-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream adder result valid.
REQ-007 in_sum  input  SUM_W  adder result s; bit SUM_W-1 is carry-out.
REQ-008 in_ready  output  1  FIFO can accept this cycle.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_sum  output  SUM_W  head entry.
REQ-011 out_ready  input  1  consumer takes head this cycle.
REQ-012 level  output  clog2(DEPTH)+1  current occupancy.
REQ-013 carry_cnt  output  CCNT_W  count of accepted sums with carry-out set.
REQ-014 clr_cnt  input  1  synchronous clear of carry_cnt.

Function
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready SHALL equal (level != DEPTH), registered-state-derived, no combinational path from out_ready.
REQ-017 out_valid SHALL equal (level != 0); out_sum SHALL present the oldest entry (first-word-fall-through).
REQ-018 Latency: a sum pushed into an empty FIFO at edge N SHALL appear on out_sum with out_valid=1 after edge N.
REQ-019 Full FIFO: in_ready=0; in_valid ignored; no entry overwritten; simultaneous pop frees one slot visible after the edge.
REQ-020 Empty FIFO: out_valid=0; out_ready ignored; no bypass of in_sum to out_sum.
REQ-021 Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL be delivered in strict arrival order across wrap.
REQ-023 carry_cnt SHALL increment by 1 on each push with in_sum[SUM_W-1]=1, saturating at all-ones.
REQ-024 clr_cnt=1 SHALL set carry_cnt to 0 after the edge; clr_cnt takes priority over a same-cycle increment.
REQ-025 in_sum and out_sum SHALL be passed bit-exact; no arithmetic on data.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set level=0, pointers=0, carry_cnt=0, hence out_valid=0, in_ready=1.
REQ-027 Storage contents need not be reset; out_sum is don't-care while out_valid=0.
REQ-028 Reset mid-operation SHALL discard all queued entries; no push or pop completes on a reset cycle.

Structure
REQ-029 Package adder_pkg SHALL hold OPND_W=64, SUM_W=OPND_W+1 and the sum typedef, shared with the adder.
REQ-030 Single module, no sub-modules; storage is a register array indexed by pointers.

Verification
REQ-031 Reset then push 65'h0_0000_0000_0000_0003 with out_ready=0 -> next cycle out_valid=1, out_sum=3, level=1.
REQ-032 Push 4 sums 1,2,3,4 with out_ready=0 -> level=4, in_ready=0; 5th in_valid ignored; drain yields 1,2,3,4 in order.
REQ-033 Push 65'h1_0000_0000_0000_0000 three times -> carry_cnt=3; clr_cnt with same-cycle carry push -> carry_cnt=0.
REQ-034 Continuous push/pop of 10 sums 0..9 with out_ready=1 -> level stays 1, outputs 0..9 in order across pointer wrap.
REQ-035 Fill to level=3 then rst_n=0 for one cycle -> level=0, out_valid=0, in_ready=1, carry_cnt=0.
REQ-036 Preload carry_cnt to 16'hFFFF via 65535 carry pushes, push one more carry sum -> carry_cnt remains 16'hFFFF.
